// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//   Round-robin arbiter sharing one WIDTH-bit register (q) among NREQ
//   requesters. A grant takes two cycles: an ARB cycle picks the next
//   requester starting from the rotating pointer, and a WRT cycle loads that
//   requester's word into q, tags it with the owner index and pulses ack.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [NREQ-1:0]        request per requester, held until ack
//   d        in   [NREQ*WIDTH-1:0]  data, requester i on d[i*WIDTH +: WIDTH]
//   clr      in   synchronous clear of q / q_valid
//   ack      out  [NREQ-1:0]        one-cycle registered grant-complete pulse
//   q        out  [WIDTH-1:0]       shared register contents
//   q_owner  out  [OW-1:0]          index of the requester that last wrote q
//   q_valid  out  q holds written data
//   busy     out  high while in the WRT state
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] d,
    input  logic                  clr,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic [OW-1:0]         q_owner,
    output logic                  q_valid,
    output logic                  busy
);

    localparam int unsigned NR = NREQ;

    typedef enum logic {
        ARB = 1'b0,
        WRT = 1'b1
    } state_t;

    state_t            r_state;
    logic [OW-1:0]     r_ptr;
    logic [OW-1:0]     r_sel;
    logic [NREQ-1:0]   r_ack;
    logic [WIDTH-1:0]  r_q;
    logic [OW-1:0]     r_owner;
    logic              r_valid;

    logic [NREQ-1:0]   w_reqe;
    logic [OW:0]       w_idx;
    logic              w_found;
    logic [OW-1:0]     w_grant;
    logic [WIDTH-1:0]  w_dsel;
    logic              w_req_sel;
    logic [OW-1:0]     w_ptr_nxt;
    logic [NREQ-1:0]   w_ack_set;

    // A requester whose ack is currently high is masked so it cannot be
    // re-granted before it has had a chance to drop req.
    assign w_reqe = req & ~r_ack;

    // Rotating priority scan: ptr, ptr+1 .. NREQ-1, 0 .. ptr-1.
    // w_idx is one bit wider than the pointer so ptr+k can be wrapped
    // without a modulo operator.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            w_idx = {1'b0, r_ptr} + (OW+1)'(k);
            if (w_idx >= (OW+1)'(NR)) begin
                w_idx = w_idx - (OW+1)'(NR);
            end
            if (!w_found && w_reqe[w_idx[OW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[OW-1:0];
            end
        end
    end

    // Word and request of the currently selected requester.
    always_comb begin
        w_dsel    = '0;
        w_req_sel = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (r_sel == OW'(i)) begin
                w_dsel    = d[i*WIDTH +: WIDTH];
                w_req_sel = req[i];
            end
        end
    end

    assign w_ptr_nxt = (r_sel == OW'(NR - 1)) ? '0 : r_sel + OW'(1);
    assign w_ack_set = NREQ'(1) << r_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ARB: begin
                    if (clr) begin
                        r_q     <= '0;
                        r_valid <= 1'b0;
                    end
                    if (w_found) begin
                        r_sel   <= w_grant;
                        r_state <= WRT;
                    end
                end
                WRT: begin
                    r_state <= ARB;
                    if (clr) begin
                        // Clear wins; the requester stays pending and is
                        // re-arbitrated from the unchanged pointer.
                        r_q     <= '0;
                        r_valid <= 1'b0;
                    end else if (w_req_sel) begin
                        r_q     <= w_dsel;
                        r_owner <= r_sel;
                        r_valid <= 1'b1;
                        r_ack   <= w_ack_set;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign ack     = r_ack;
    assign q       = r_q;
    assign q_owner = r_owner;
    assign q_valid = r_valid;
    assign busy    = (r_state == WRT);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter
//   Directed bench for dff_bank_arbiter (NREQ=4, WIDTH=8). The stimulus
//   process pushes the expected {owner, word} of every grant it provokes;
//   a monitor pops and compares whenever ack is seen high. Reset, clear,
//   withdrawal and latency checks are made inline by the stimulus process.
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int OW    = 2;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  clr   = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] d     = '0;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [OW-1:0]         q_owner;
    logic                  q_valid;
    logic                  busy;

    typedef struct packed {
        logic [OW-1:0]    owner;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    dff_bank_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .clr     (clr),
        .ack     (ack),
        .q       (q),
        .q_owner (q_owner),
        .q_valid (q_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int owner, input logic [7:0] data);
        exp_t e;
        e.owner = OW'(owner);
        e.data  = data;
        sb.push_back(e);
    endtask

    task automatic setd(input int i, input logic [7:0] v);
        d[i*WIDTH +: WIDTH] = v;
    endtask

    // Waits (at negedges) for n acks; optionally drops req of each acked
    // requester in the ack cycle. Returns the number of negedges elapsed.
    task automatic wait_acks(input int n, input int budget, input bit drop, output int el);
        int got;
        got = 0;
        el  = 0;
        while (got < n && el < budget) begin
            @(negedge clk);
            el++;
            if (ack != '0) begin
                got++;
                if (drop) req = req & ~ack;
            end
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", got, n);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ack != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got %b expected none", ack);
            end else begin
                e = sb.pop_front();
                chk("ack",     32'(ack),     32'(NREQ'(1) << e.owner));
                chk("q",       32'(q),       32'(e.data));
                chk("q_owner", 32'(q_owner), 32'(e.owner));
                chk("q_valid", 32'(q_valid), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int el;

        // Reset state
        @(negedge clk);
        chk("rst_q",       32'(q),       32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_q_owner", 32'(q_owner), 32'h0);
        chk("rst_ack",     32'(ack),     32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        rst_n = 1'b1;

        // Single request from requester 1
        @(negedge clk);
        setd(1, 8'hA5);
        req = 4'b0010;
        push(1, 8'hA5);
        @(negedge clk);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_noack", 32'(ack), 32'h0);
        wait_acks(1, 10, 1'b1, el);
        chk("single_latency", 32'(el), 32'd1);
        @(negedge clk);
        chk("single_ack_pulse", 32'(ack), 32'h0);
        chk("single_idle", 32'(busy), 32'h0);

        // Grant requester 2 (ptr -> 3), then 1001 must go 3 then 0
        setd(2, 8'hC3);
        req = 4'b0100;
        push(2, 8'hC3);
        wait_acks(1, 10, 1'b1, el);
        setd(0, 8'h90);
        setd(3, 8'h93);
        req = 4'b1001;
        push(3, 8'h93);
        push(0, 8'h90);
        wait_acks(2, 12, 1'b1, el);
        chk("wrap_cycles", 32'(el), 32'd4);

        // Load 3C, then assert reset in the middle of the next WRT
        setd(0, 8'h3C);
        req = 4'b0001;
        push(0, 8'h3C);
        wait_acks(1, 10, 1'b1, el);
        setd(2, 8'hE7);
        req = 4'b0100;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'h1);
        chk("pre_rst_q",    32'(q),    32'h3C);
        #1;
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("async_rst_q",       32'(q),       32'h0);
        chk("async_rst_q_valid", 32'(q_valid), 32'h0);
        chk("async_rst_ack",     32'(ack),     32'h0);
        chk("async_rst_busy",    32'(busy),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: all four held, ptr=0 after reset
        d   = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        req = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            push(0, 8'hF0);
            push(1, 8'hF1);
            push(2, 8'hF2);
            push(3, 8'hF3);
        end
        wait_acks(8, 40, 1'b0, el);
        req = '0;
        chk("fair_throughput", 32'(el), 32'd16);
        @(negedge clk);
        chk("fair_idle", 32'(busy), 32'h0);

        // clr collides with the WRT cycle of requester 1
        setd(1, 8'h5A);
        req = 4'b0010;
        push(1, 8'h5A);
        @(negedge clk);
        chk("clr_busy", 32'(busy), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_q",       32'(q),       32'h0);
        chk("clr_q_valid", 32'(q_valid), 32'h0);
        chk("clr_noack",   32'(ack),     32'h0);
        chk("clr_busy_lo", 32'(busy),    32'h0);
        wait_acks(1, 10, 1'b1, el);
        chk("clr_regrant_latency", 32'(el), 32'd2);

        // Withdrawal: ptr=2, requester 2 drops req during its WRT
        setd(2, 8'h77);
        setd(3, 8'h88);
        req = 4'b1100;
        @(negedge clk);
        chk("wd_busy", 32'(busy), 32'h1);
        req = 4'b1000;
        @(negedge clk);
        chk("wd_noack",   32'(ack),     32'h0);
        chk("wd_q",       32'(q),       32'h5A);
        chk("wd_q_owner", 32'(q_owner), 32'h1);
        chk("wd_busy_lo", 32'(busy),    32'h0);
        // Pointer must still be 2: requester 2 re-requests and wins over 3
        req = 4'b1100;
        push(2, 8'h77);
        push(3, 8'h88);
        wait_acks(2, 12, 1'b1, el);
        chk("wd_cycles", 32'(el), 32'd4);

        // clr while idle in ARB
        @(negedge clk);
        chk("arb_pre_q_valid", 32'(q_valid), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("arb_clr_q",       32'(q),       32'h0);
        chk("arb_clr_q_valid", 32'(q_valid), 32'h0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("final_ack", 32'(ack), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
